// File: rtl/global_param_loader_pkg.sv
// -----------------------------------------------------------------------------
// global_param_loader_pkg
//   Shared definitions for the global parameter loader:
//     - loader state encoding (FILL / FULL)
//     - run state encoding (IDLE / RUN)
//     - frame geometry for the default configuration, plus helper functions
//       that derive the same geometry for any parameter set
//     - parameter word index constants
// -----------------------------------------------------------------------------
package global_param_loader_pkg;

    typedef enum logic {
        LD_FILL = 1'b0,
        LD_FULL = 1'b1
    } ld_state_e;

    typedef enum logic {
        RUN_IDLE = 1'b0,
        RUN_RUN  = 1'b1
    } run_state_e;

    // Default geometry (NUM_PARAMS=4, DATA_W=8, CNT_W=8).
    localparam int DEF_NUM_PARAMS  = 4;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_CNT_W       = 8;
    localparam int BYTES_PER_PARAM = DEF_DATA_W / 8;
    localparam int CNT_BYTES       = DEF_CNT_W / 8;
    localparam int FRAME_BYTES     = DEF_NUM_PARAMS * BYTES_PER_PARAM + CNT_BYTES;
    localparam int IDX_W           = $clog2(FRAME_BYTES);

    // Conventional meaning of the parameter words.
    localparam int PAR_X     = 0;
    localparam int PAR_Y     = 1;
    localparam int PAR_ZOOM  = 2;
    localparam int PAR_ANGLE = 3;

    // Number of stream bytes making up one complete parameter frame.
    function automatic int frame_bytes(input int num_params, input int data_w,
                                       input int cnt_w);
        return num_params * (data_w / 8) + cnt_w / 8;
    endfunction

    // Byte index width; never narrower than one bit.
    function automatic int idx_width(input int fbytes);
        return (fbytes > 1) ? $clog2(fbytes) : 1;
    endfunction

endpackage

// File: rtl/global_param_loader_if.sv
// -----------------------------------------------------------------------------
// global_param_loader_if
//   Host byte stream into the loader.
//     S_DATA   8-bit stream byte
//     S_VALID  byte valid (host -> loader)
//     S_READY  loader can accept a byte (loader -> host)
//   A byte moves on a rising clock edge where S_VALID && S_READY.
//   master: host side, slave: loader side.
// -----------------------------------------------------------------------------
interface global_param_loader_if;
    logic [7:0] S_DATA;
    logic       S_VALID;
    logic       S_READY;

    modport master (
        output S_DATA,
        output S_VALID,
        input  S_READY
    );

    modport slave (
        input  S_DATA,
        input  S_VALID,
        output S_READY
    );
endinterface

// File: rtl/global_param_loader_param_shadow_loader.sv
// -----------------------------------------------------------------------------
// param_shadow_loader
//   Assembles one parameter frame from the byte stream into the shadow bank.
//   Ports:
//     clk, rst_n      clock, synchronous active-low reset
//     s_in            byte stream (slave side), S_READY driven here
//     flush           discard partial or pending frame, restart at byte 0
//     commit          the top level is moving the shadow bank to the active
//                     bank at this edge (already excludes flush)
//     loaded          shadow frame complete and waiting for commit
//     shadow_params   parameter words of the shadow frame
//     shadow_count    repeat count of the shadow frame
//   Bytes land at the current byte index; words are little-endian, params
//   first, count last, so the frame is simply a flat byte array.
// -----------------------------------------------------------------------------
module param_shadow_loader
    import global_param_loader_pkg::*;
#(
    parameter int NUM_PARAMS = 4,
    parameter int DATA_W     = 8,
    parameter int CNT_W      = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    global_param_loader_if.slave         s_in,
    input  logic                         flush,
    input  logic                         commit,
    output logic                         loaded,
    output logic [NUM_PARAMS*DATA_W-1:0] shadow_params,
    output logic [CNT_W-1:0]             shadow_count
);

    localparam int FB = frame_bytes(NUM_PARAMS, DATA_W, CNT_W);
    localparam int IW = idx_width(FB);
    localparam int PW = NUM_PARAMS * DATA_W;

    ld_state_e        state_q;
    logic [IW-1:0]    idx_q;
    logic [FB*8-1:0]  frame_q;
    logic [FB*8-1:0]  frame_d;
    logic             ready_q;
    logic             loaded_q;
    logic             xfer;
    logic             last_byte;

    // ready_q is only ever high in FILL, so a transfer implies FILL.
    assign xfer      = s_in.S_VALID && ready_q;
    assign last_byte = (idx_q == IW'(FB - 1));

    // A byte dropped by a simultaneous flush is not written.
    always_comb begin
        frame_d = frame_q;
        if (xfer && !flush) begin
            for (int b = 0; b < FB; b++) begin
                if (idx_q == IW'(b)) begin
                    frame_d[b*8 +: 8] = s_in.S_DATA;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= LD_FILL;
            idx_q    <= '0;
            frame_q  <= '0;
            ready_q  <= 1'b0;
            loaded_q <= 1'b0;
        end else begin
            frame_q <= frame_d;
            if (flush) begin
                state_q  <= LD_FILL;
                idx_q    <= '0;
                ready_q  <= 1'b1;
                loaded_q <= 1'b0;
            end else begin
                case (state_q)
                    LD_FILL: begin
                        // Also raises ready on the first edge after reset.
                        ready_q  <= 1'b1;
                        loaded_q <= 1'b0;
                        if (xfer) begin
                            if (last_byte) begin
                                idx_q    <= '0;
                                state_q  <= LD_FULL;
                                ready_q  <= 1'b0;
                                loaded_q <= 1'b1;
                            end else begin
                                idx_q <= idx_q + IW'(1);
                            end
                        end
                    end
                    LD_FULL: begin
                        if (commit) begin
                            state_q  <= LD_FILL;
                            idx_q    <= '0;
                            ready_q  <= 1'b1;
                            loaded_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q  <= LD_FILL;
                        idx_q    <= '0;
                        ready_q  <= 1'b1;
                        loaded_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign s_in.S_READY  = ready_q;
    assign loaded        = loaded_q;
    assign shadow_params = frame_q[PW-1:0];
    assign shadow_count  = frame_q[PW +: CNT_W];

endmodule

// File: rtl/global_param_loader.sv
// -----------------------------------------------------------------------------
// global_param_loader
//   Double-buffered loader for the per-frame global parameters (centre X/Y,
//   zoom, angle) and a repeat count. A frame is assembled into a shadow bank,
//   committed atomically to the active bank, and the run then counts NEXT
//   pulses down to FINISH. The following frame may be preloaded meanwhile.
//   Ports:
//     ACLK, ARESETN  clock, synchronous active-low reset
//     s_axis         host byte stream (S_DATA/S_VALID/S_READY)
//     FLUSH          discard partial or pending shadow frame
//     NEXT           frame-advance pulse from the pipeline
//     PARAMS         active bank, word i at [i*DATA_W +: DATA_W]
//     RUN_COUNT      remaining count of the active run
//     ACTIVE         a run is in progress
//     LOADED         shadow frame complete and awaiting commit
//     COMMIT         one-cycle pulse: shadow moved to active bank
//     FINISH         one-cycle pulse: the run ended
// -----------------------------------------------------------------------------
module global_param_loader
    import global_param_loader_pkg::*;
#(
    parameter int NUM_PARAMS = 4,
    parameter int DATA_W     = 8,
    parameter int CNT_W      = 8
) (
    input  logic                         ACLK,
    input  logic                         ARESETN,
    global_param_loader_if.slave         s_axis,
    input  logic                         FLUSH,
    input  logic                         NEXT,
    output logic [NUM_PARAMS*DATA_W-1:0] PARAMS,
    output logic [CNT_W-1:0]             RUN_COUNT,
    output logic                         ACTIVE,
    output logic                         LOADED,
    output logic                         COMMIT,
    output logic                         FINISH
);

    localparam int PW = NUM_PARAMS * DATA_W;

    logic             loaded;
    logic [PW-1:0]    shadow_params;
    logic [CNT_W-1:0] shadow_count;

    run_state_e       run_state_q;
    logic [PW-1:0]    params_q;
    logic [CNT_W-1:0] run_cnt_q;
    logic             active_q;
    logic             commit_q;
    logic             finish_q;

    logic             run_ends;
    logic             commit_now;

    param_shadow_loader #(
        .NUM_PARAMS (NUM_PARAMS),
        .DATA_W     (DATA_W),
        .CNT_W      (CNT_W)
    ) u_shadow (
        .clk           (ACLK),
        .rst_n         (ARESETN),
        .s_in          (s_axis),
        .flush         (FLUSH),
        .commit        (commit_now),
        .loaded        (loaded),
        .shadow_params (shadow_params),
        .shadow_count  (shadow_count)
    );

    // Counts of 0 and 1 both end on the first NEXT, so the count never wraps.
    // A commit is allowed into an idle run or into the edge where the current
    // run ends, which gives seamless back-to-back runs. FLUSH always wins.
    always_comb begin
        run_ends   = (run_state_q == RUN_RUN) && NEXT &&
                     (run_cnt_q <= CNT_W'(1));
        commit_now = loaded && !FLUSH &&
                     ((run_state_q == RUN_IDLE) || run_ends);
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            run_state_q <= RUN_IDLE;
            params_q    <= '0;
            run_cnt_q   <= '0;
            active_q    <= 1'b0;
            commit_q    <= 1'b0;
            finish_q    <= 1'b0;
        end else begin
            commit_q <= commit_now;
            finish_q <= run_ends;
            if (commit_now) begin
                // NEXT at this edge is not counted against the new run.
                params_q    <= shadow_params;
                run_cnt_q   <= shadow_count;
                active_q    <= 1'b1;
                run_state_q <= RUN_RUN;
            end else if (run_ends) begin
                // PARAMS deliberately held until the next commit.
                run_cnt_q   <= '0;
                active_q    <= 1'b0;
                run_state_q <= RUN_IDLE;
            end else if ((run_state_q == RUN_RUN) && NEXT) begin
                run_cnt_q <= run_cnt_q - CNT_W'(1);
            end
        end
    end

    assign PARAMS    = params_q;
    assign RUN_COUNT = run_cnt_q;
    assign ACTIVE    = active_q;
    assign LOADED    = loaded;
    assign COMMIT    = commit_q;
    assign FINISH    = finish_q;

endmodule

// File: tb/tb_global_param_loader.sv
// -----------------------------------------------------------------------------
// tb_global_param_loader
//   Bench for global_param_loader: a default instance (4 x 8-bit params,
//   8-bit count) driven by directed scenarios and random traffic against a
//   frame-level reference model, and a 2 x 16-bit / 16-bit-count instance for
//   the wide-word frame format.
// -----------------------------------------------------------------------------
module tb_global_param_loader;

    localparam int FB = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance
    global_param_loader_if ifa ();
    logic        rst_n, flush, next_p;
    logic [31:0] params_a;
    logic [7:0]  cnt_a;
    logic        active_a, loaded_a, commit_a, finish_a;
    logic [4:0]  flags_a;
    assign flags_a = {active_a, loaded_a, commit_a, finish_a, ifa.S_READY};

    global_param_loader #(.NUM_PARAMS(4), .DATA_W(8), .CNT_W(8)) dut_a (
        .ACLK(clk), .ARESETN(rst_n), .s_axis(ifa), .FLUSH(flush), .NEXT(next_p),
        .PARAMS(params_a), .RUN_COUNT(cnt_a), .ACTIVE(active_a),
        .LOADED(loaded_a), .COMMIT(commit_a), .FINISH(finish_a)
    );

    // Wide-word instance
    global_param_loader_if ifb ();
    logic        rst_n_b, flush_b, next_b;
    logic [31:0] params_b;
    logic [15:0] cnt_b;
    logic        active_b, loaded_b, commit_b, finish_b;

    global_param_loader #(.NUM_PARAMS(2), .DATA_W(16), .CNT_W(16)) dut_b (
        .ACLK(clk), .ARESETN(rst_n_b), .s_axis(ifb), .FLUSH(flush_b), .NEXT(next_b),
        .PARAMS(params_b), .RUN_COUNT(cnt_b), .ACTIVE(active_b),
        .LOADED(loaded_b), .COMMIT(commit_b), .FINISH(finish_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: shadow frame as a byte queue, active run as numbers.
    logic [7:0]  bq[$];
    logic [31:0] m_params;
    int          m_count;
    bit          m_active, m_commit, m_finish, m_inrst;

    function automatic logic [44:0] model_vec();
        bit full, rdy;
        full = !m_inrst && (bq.size() == FB);
        rdy  = !m_inrst && (bq.size() < FB);
        return {m_params, m_count[7:0], m_active, full, m_commit, m_finish, rdy};
    endfunction

    // Drive one cycle on the default instance and advance the model.
    task automatic step(input logic rn, input logic vld, input logic [7:0] d,
                        input logic fl, input logic nx);
        bit full, rdy, ends, com;
        rst_n = rn; ifa.S_VALID = vld; ifa.S_DATA = d; flush = fl; next_p = nx;
        if (!rn) begin
            bq.delete();
            m_params = '0; m_count = 0; m_active = 0;
            m_commit = 0; m_finish = 0; m_inrst = 1;
        end else begin
            full = !m_inrst && (bq.size() == FB);
            rdy  = !m_inrst && (bq.size() < FB);
            ends = m_active && nx && (m_count <= 1);
            com  = full && !fl && (!m_active || ends);
            m_commit = com;
            m_finish = ends;
            if (com) begin
                for (int i = 0; i < 4; i++) m_params[8*i +: 8] = bq[i];
                m_count  = int'(bq[4]);
                m_active = 1;
                bq.delete();
            end else if (ends) begin
                m_count  = 0;
                m_active = 0;
            end else if (m_active && nx) begin
                m_count = m_count - 1;
            end
            if (fl) bq.delete();
            else if (rdy && vld) bq.push_back(d);
            m_inrst = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send5(input logic [39:0] fr);
        for (int i = 0; i < 5; i++) step(1, 1, fr[8*i +: 8], 0, 0);
    endtask

    task automatic test_reset();
        step(0, 0, 8'h00, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        n_checks++; if (flags_a !== 5'b00000) $display("FAIL reset_flags: got %b expected %b", flags_a, 5'b00000); else n_pass++;
        n_checks++; if ({params_a, cnt_a} !== 40'h0) $display("FAIL reset_data: got %h expected %h", {params_a, cnt_a}, 40'h0); else n_pass++;
        step(1, 0, 8'h00, 0, 0);
        n_checks++; if (flags_a !== 5'b00001) $display("FAIL reset_release: got %b expected %b", flags_a, 5'b00001); else n_pass++;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) step(1, 1, 8'h10 * (i + 1), 0, 0);
        n_checks++; if (flags_a !== 5'b00001) $display("FAIL basic_partial: got %b expected %b", flags_a, 5'b00001); else n_pass++;
        step(1, 1, 8'h02, 0, 0);
        n_checks++; if (flags_a !== 5'b01000) $display("FAIL basic_loaded: got %b expected %b", flags_a, 5'b01000); else n_pass++;
        step(1, 0, 8'h00, 0, 0);
        n_checks++; if (flags_a !== 5'b10101) $display("FAIL basic_commit: got %b expected %b", flags_a, 5'b10101); else n_pass++;
        n_checks++; if (params_a !== 32'h40302010) $display("FAIL basic_params: got %h expected %h", params_a, 32'h40302010); else n_pass++;
        n_checks++; if (cnt_a !== 8'd2) $display("FAIL basic_count: got %0d expected %0d", cnt_a, 2); else n_pass++;
        step(1, 0, 8'h00, 0, 1);
        n_checks++; if ({flags_a, cnt_a} !== {5'b10001, 8'd1}) $display("FAIL basic_next1: got %h expected %h", {flags_a, cnt_a}, {5'b10001, 8'd1}); else n_pass++;
        step(1, 0, 8'h00, 0, 1);
        n_checks++; if ({flags_a, cnt_a} !== {5'b00011, 8'd0}) $display("FAIL basic_finish: got %h expected %h", {flags_a, cnt_a}, {5'b00011, 8'd0}); else n_pass++;
        step(1, 0, 8'h00, 0, 0);
        n_checks++; if ({flags_a, params_a} !== {5'b00001, 32'h40302010}) $display("FAIL basic_hold: got %h expected %h", {flags_a, params_a}, {5'b00001, 32'h40302010}); else n_pass++;
    endtask

    task automatic test_preload();
        send5(40'h03_04030201);
        step(1, 0, 8'h00, 0, 0);
        send5(40'h01_DDCCBBAA);
        n_checks++; if ({flags_a, cnt_a} !== {5'b11000, 8'd3}) $display("FAIL preload_loaded: got %h expected %h", {flags_a, cnt_a}, {5'b11000, 8'd3}); else n_pass++;
        step(1, 0, 8'h00, 0, 1);
        step(1, 0, 8'h00, 0, 1);
        n_checks++; if ({flags_a, cnt_a} !== {5'b11000, 8'd1}) $display("FAIL preload_count: got %h expected %h", {flags_a, cnt_a}, {5'b11000, 8'd1}); else n_pass++;
        step(1, 0, 8'h00, 0, 1);
        n_checks++; if ({flags_a, cnt_a} !== {5'b10111, 8'd1}) $display("FAIL preload_b2b: got %h expected %h", {flags_a, cnt_a}, {5'b10111, 8'd1}); else n_pass++;
        n_checks++; if (params_a !== 32'hDDCCBBAA) $display("FAIL preload_params: got %h expected %h", params_a, 32'hDDCCBBAA); else n_pass++;
        step(1, 0, 8'h00, 0, 1);
        n_checks++; if ({flags_a, cnt_a} !== {5'b00011, 8'd0}) $display("FAIL preload_finish: got %h expected %h", {flags_a, cnt_a}, {5'b00011, 8'd0}); else n_pass++;
    endtask

    task automatic test_zero_count();
        send5(40'h00_44332211);
        step(1, 0, 8'h00, 0, 0);
        n_checks++; if ({flags_a, cnt_a} !== {5'b10101, 8'd0}) $display("FAIL zero_commit: got %h expected %h", {flags_a, cnt_a}, {5'b10101, 8'd0}); else n_pass++;
        step(1, 0, 8'h00, 0, 1);
        n_checks++; if ({flags_a, cnt_a} !== {5'b00011, 8'd0}) $display("FAIL zero_finish: got %h expected %h", {flags_a, cnt_a}, {5'b00011, 8'd0}); else n_pass++;
        step(1, 0, 8'h00, 0, 1);
        n_checks++; if ({flags_a, cnt_a} !== {5'b00001, 8'd0}) $display("FAIL zero_nowrap: got %h expected %h", {flags_a, cnt_a}, {5'b00001, 8'd0}); else n_pass++;
    endtask

    task automatic test_flush();
        step(1, 1, 8'hE1, 0, 0);
        step(1, 1, 8'hE2, 0, 0);
        step(1, 1, 8'hE3, 0, 0);
        step(1, 1, 8'h99, 1, 0);
        n_checks++; if (flags_a !== 5'b00001) $display("FAIL flush_partial: got %b expected %b", flags_a, 5'b00001); else n_pass++;
        for (int i = 0; i < 4; i++) step(1, 1, 8'h5A + 8'(i * 17), 0, 0);
        n_checks++; if (flags_a !== 5'b00001) $display("FAIL flush_index: got %b expected %b", flags_a, 5'b00001); else n_pass++;
        step(1, 1, 8'h01, 0, 0);
        step(1, 0, 8'h00, 0, 0);
        n_checks++; if ({flags_a, params_a} !== {5'b10101, 32'h8D7C6B5A}) $display("FAIL flush_commit: got %h expected %h", {flags_a, params_a}, {5'b10101, 32'h8D7C6B5A}); else n_pass++;
        // Flush of a pending frame during a run.
        send5(40'h05_01010101);
        step(1, 0, 8'h00, 1, 0);
        n_checks++; if (flags_a !== 5'b10001) $display("FAIL flush_full: got %b expected %b", flags_a, 5'b10001); else n_pass++;
        step(1, 0, 8'h00, 0, 1);
        step(1, 0, 8'h00, 0, 0);
        n_checks++; if ({flags_a, params_a} !== {5'b00001, 32'h8D7C6B5A}) $display("FAIL flush_nocommit: got %h expected %h", {flags_a, params_a}, {5'b00001, 32'h8D7C6B5A}); else n_pass++;
        // Flush beats a commit at the run's final edge.
        send5(40'h01_24232221);
        step(1, 0, 8'h00, 0, 0);
        send5(40'h02_34333231);
        step(1, 0, 8'h00, 1, 1);
        n_checks++; if ({flags_a, params_a} !== {5'b00011, 32'h24232221}) $display("FAIL flush_beats_commit: got %h expected %h", {flags_a, params_a}, {5'b00011, 32'h24232221}); else n_pass++;
    endtask

    task automatic test_reset_mid();
        step(1, 1, 8'hF1, 0, 0);
        step(1, 1, 8'hF2, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        n_checks++; if ({flags_a, params_a, cnt_a} !== 45'h0) $display("FAIL rstmid_frame: got %h expected %h", {flags_a, params_a, cnt_a}, 45'h0); else n_pass++;
        step(1, 0, 8'h00, 0, 0);
        n_checks++; if (flags_a !== 5'b00001) $display("FAIL rstmid_release: got %b expected %b", flags_a, 5'b00001); else n_pass++;
        send5(40'h04_44434241);
        step(1, 0, 8'h00, 0, 0);
        n_checks++; if ({params_a, cnt_a} !== {32'h44434241, 8'd4}) $display("FAIL rstmid_newframe: got %h expected %h", {params_a, cnt_a}, {32'h44434241, 8'd4}); else n_pass++;
        step(1, 0, 8'h00, 0, 1);
        step(0, 0, 8'h00, 0, 1);
        n_checks++; if ({flags_a, params_a, cnt_a} !== 45'h0) $display("FAIL rstmid_run: got %h expected %h", {flags_a, params_a, cnt_a}, 45'h0); else n_pass++;
        step(1, 0, 8'h00, 0, 0);
        n_checks++; if (flags_a !== 5'b00001) $display("FAIL rstmid_nopulse: got %b expected %b", flags_a, 5'b00001); else n_pass++;
    endtask

    task automatic step_b(input logic rn, input logic vld, input logic [7:0] d);
        rst_n_b = rn; ifb.S_VALID = vld; ifb.S_DATA = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_width();
        logic [47:0] fr;
        fr = 48'h0003_56781234;
        step_b(0, 0, 8'h00);
        step_b(0, 0, 8'h00);
        step_b(1, 0, 8'h00);
        n_checks++; if (ifb.S_READY !== 1'b1) $display("FAIL width_ready: got %b expected %b", ifb.S_READY, 1'b1); else n_pass++;
        for (int i = 0; i < 5; i++) step_b(1, 1, fr[8*i +: 8]);
        n_checks++; if (loaded_b !== 1'b0) $display("FAIL width_partial: got %b expected %b", loaded_b, 1'b0); else n_pass++;
        step_b(1, 1, fr[47:40]);
        n_checks++; if (loaded_b !== 1'b1) $display("FAIL width_loaded: got %b expected %b", loaded_b, 1'b1); else n_pass++;
        step_b(1, 0, 8'h00);
        n_checks++; if ({commit_b, active_b, params_b, cnt_b} !== {2'b11, 32'h56781234, 16'h0003}) $display("FAIL width_commit: got %h expected %h", {commit_b, active_b, params_b, cnt_b}, {2'b11, 32'h56781234, 16'h0003}); else n_pass++;
    endtask

    task automatic test_random();
        logic [44:0] exp_v, act_v;
        logic        vld, fl, nx, rn;
        logic [7:0]  d;
        step(0, 0, 8'h00, 0, 0);
        for (int c = 0; c < 600; c++) begin
            rn  = ($urandom_range(0, 199) != 0);
            vld = ($urandom_range(0, 2) != 0);
            fl  = ($urandom_range(0, 24) == 0);
            nx  = ($urandom_range(0, 2) == 0);
            d   = (bq.size() == FB - 1) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 255));
            step(rn, vld, d, fl, nx);
            exp_v = model_vec();
            act_v = {params_a, cnt_a, flags_a};
            n_checks++; if (act_v !== exp_v) $display("FAIL random_cycle%0d: got %h expected %h", c, act_v, exp_v); else n_pass++;
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; next_p = 1'b0;
        ifa.S_VALID = 1'b0; ifa.S_DATA = 8'h00;
        rst_n_b = 1'b0; flush_b = 1'b0; next_b = 1'b0;
        ifb.S_VALID = 1'b0; ifb.S_DATA = 8'h00;
        test_reset();
        test_basic();
        test_preload();
        test_zero_count();
        test_flush();
        test_reset_mid();
        test_width();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
